// File: rtl/control_unit_pkg.sv
// Shared control encodings for the multicycle CPU: states, opcodes/functs,
// datapath select values and exception vectors.
package cpu_ctrl_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_RESET  = 5'd0;
  localparam state_t S_FETCH  = 5'd1;
  localparam state_t S_DECODE = 5'd2;
  localparam state_t S_EXEC_R = 5'd3;
  localparam state_t S_WB_R   = 5'd4;
  localparam state_t S_EXEC_I = 5'd5;
  localparam state_t S_WB_I   = 5'd6;
  localparam state_t S_SH_LD  = 5'd7;
  localparam state_t S_SH_OP  = 5'd8;
  localparam state_t S_SH_WB  = 5'd9;
  localparam state_t S_ADDR   = 5'd10;
  localparam state_t S_MEM_RD = 5'd11;
  localparam state_t S_WB_MEM = 5'd12;
  localparam state_t S_MEM_WR = 5'd13;
  localparam state_t S_BRANCH = 5'd14;
  localparam state_t S_JUMP   = 5'd15;
  localparam state_t S_JR     = 5'd16;
  localparam state_t S_WB_HL  = 5'd17;
  localparam state_t S_MULDIV = 5'd18;
  localparam state_t S_EXC1   = 5'd19;
  localparam state_t S_EXC2   = 5'd20;
  localparam state_t S_EXC3   = 5'd21;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23,
                         OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_JR   = 6'h08,
                         F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18,
                         F_DIV  = 6'h1A, F_ADD  = 6'h20, F_SUB  = 6'h22,
                         F_AND  = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000, ALU_ADD = 3'b001,
                         ALU_SUB  = 3'b010, ALU_AND = 3'b011;
  localparam logic [2:0] SH_NOP = 3'b000, SH_LOAD = 3'b001,
                         SH_SLL = 3'b010, SH_SRL  = 3'b011;

  localparam logic [3:0] SRCB_B = 4'd0, SRCB_4 = 4'd1, SRCB_SEXT = 4'd2, SRCB_SEXT_SH = 4'd3;
  localparam logic [3:0] PCS_ALURES = 4'd0, PCS_ALUOUT = 4'd1, PCS_JUMP = 4'd2, PCS_VECTOR = 4'd3;
  localparam logic [3:0] RDST_RT = 4'd0, RDST_RD = 4'd1;
  localparam logic [3:0] M2R_WSRC = 4'd0, M2R_MDR = 4'd1, M2R_SHIFT = 4'd2;
  localparam logic [3:0] WSRC_ALUOUT = 4'd0, WSRC_HI = 4'd1, WSRC_LO = 4'd2;
  localparam logic [3:0] EXC_OPCODE = 4'd0, EXC_OVF = 4'd1, EXC_DIV0 = 4'd2;

  localparam logic [7:0] VEC_OPCODE = 8'd253, VEC_OVF = 8'd254, VEC_DIV0 = 8'd255;

  function automatic logic [7:0] exc_vector(input logic [3:0] code);
    case (code)
      EXC_OVF:  return VEC_OVF;
      EXC_DIV0: return VEC_DIV0;
      default:  return VEC_OPCODE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: decoded instruction fields and flags in,
// selects and write enables out. master = control unit, slave = datapath.
interface control_unit_if;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       Zero, ALUoverflow, ByZero;
  logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, HIWrite, LOWrite;
  logic       IorD, AluSrcA, DivMult;
  logic [3:0] AluSrcB, PCSource, RegDest, MemToReg, WriteSrc, Exception;
  logic [2:0] ALUControl, ShiftControl;

  modport master (
    input  OPCODE, FUNCT, Zero, ALUoverflow, ByZero,
    output PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, HIWrite, LOWrite,
           IorD, AluSrcA, AluSrcB, ALUControl, ShiftControl, PCSource, RegDest,
           MemToReg, WriteSrc, Exception, DivMult
  );

  modport slave (
    output OPCODE, FUNCT, Zero, ALUoverflow, ByZero,
    input  PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, HIWrite, LOWrite,
           IorD, AluSrcA, AluSrcB, ALUControl, ShiftControl, PCSource, RegDest,
           MemToReg, WriteSrc, Exception, DivMult
  );
endinterface

// File: rtl/control_unit_wait_counter.sv
// Loadable down-counter shared by all multi-cycle states; saturates at zero.
module wait_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             done_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == '0);
endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback sequencing
// plus the EPC exception sequence. Outputs decode from state and wait count.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT      = 2,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);
  localparam int unsigned MAXW = (MULDIV_CYCLES > MEM_WAIT) ? MULDIV_CYCLES : MEM_WAIT;
  localparam int unsigned CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] LD_FETCH  = CW'(MEM_WAIT);
  localparam logic [CW-1:0] LD_MEM    = CW'(MEM_WAIT - 1);
  localparam logic [CW-1:0] LD_MULDIV = CW'(MULDIV_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      alu_q, alu_d;
  logic            alt_q, alt_d;   // variant: srl / bne / mflo / div / sw
  logic [3:0]      exc_q, exc_d;
  logic            cnt_load, cnt_done;
  logic [CW-1:0]   cnt_val, cnt;
  logic            first_md, div0;

  wait_counter #(.WIDTH(CW)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .count_o    (cnt),
    .done_o     (cnt_done)
  );

  assign first_md = (cnt == LD_MULDIV);
  assign div0     = alt_q && first_md && bus.ByZero;

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    alt_d   = alt_q;
    exc_d   = exc_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (cnt_done) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXC1;
        exc_d   = EXC_OPCODE;
        alu_d   = ALU_ADD;
        alt_d   = 1'b0;
        case (bus.OPCODE)
          OP_RTYPE: case (bus.FUNCT)
            F_ADD:  state_d = S_EXEC_R;
            F_SUB:  begin state_d = S_EXEC_R; alu_d = ALU_SUB; end
            F_AND:  begin state_d = S_EXEC_R; alu_d = ALU_AND; end
            F_SLL:  state_d = S_SH_LD;
            F_SRL:  begin state_d = S_SH_LD; alt_d = 1'b1; end
            F_JR:   state_d = S_JR;
            F_MFHI: state_d = S_WB_HL;
            F_MFLO: begin state_d = S_WB_HL; alt_d = 1'b1; end
            F_MULT: state_d = S_MULDIV;
            F_DIV:  begin state_d = S_MULDIV; alt_d = 1'b1; end
            default: ;
          endcase
          OP_ADDI: state_d = S_EXEC_I;
          OP_LW:   state_d = S_ADDR;
          OP_SW:   begin state_d = S_ADDR; alt_d = 1'b1; end
          OP_BEQ:  state_d = S_BRANCH;
          OP_BNE:  begin state_d = S_BRANCH; alt_d = 1'b1; end
          OP_J:    state_d = S_JUMP;
          default: ;
        endcase
      end
      S_EXEC_R: if (bus.ALUoverflow && alu_q != ALU_AND) begin
                  state_d = S_EXC1; exc_d = EXC_OVF;
                end else state_d = S_WB_R;
      S_EXEC_I: if (bus.ALUoverflow) begin
                  state_d = S_EXC1; exc_d = EXC_OVF;
                end else state_d = S_WB_I;
      S_SH_LD:  state_d = S_SH_OP;
      S_SH_OP:  state_d = S_SH_WB;
      S_ADDR:   state_d = alt_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (cnt_done) state_d = S_WB_MEM;
      S_MULDIV: if (div0) begin
                  state_d = S_EXC1; exc_d = EXC_DIV0;
                end else if (cnt_done) state_d = S_FETCH;
      S_EXC1:   state_d = S_EXC2;
      S_EXC2:   if (cnt_done) state_d = S_EXC3;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter reloads on every state change with the dwell of the state entered.
  always_comb begin
    cnt_load = (state_d != state_q);
    case (state_d)
      S_FETCH:          cnt_val = LD_FETCH;
      S_MEM_RD, S_EXC2: cnt_val = LD_MEM;
      S_MULDIV:         cnt_val = LD_MULDIV;
      default:          cnt_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      alu_q   <= ALU_ADD;
      alt_q   <= 1'b0;
      exc_q   <= EXC_OPCODE;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      alt_q   <= alt_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    bus.PCwrite = 1'b0;  bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0; bus.EPCWrite = 1'b0; bus.HIWrite = 1'b0; bus.LOWrite = 1'b0;
    bus.IorD = 1'b0;     bus.AluSrcA = 1'b0;  bus.DivMult = 1'b0;
    bus.AluSrcB = '0;    bus.ALUControl = '0; bus.ShiftControl = SH_NOP;
    bus.PCSource = '0;   bus.RegDest = '0;    bus.MemToReg = '0;
    bus.WriteSrc = '0;   bus.Exception = '0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1; bus.AluSrcB = SRCB_4; bus.ALUControl = ALU_ADD;
        bus.IRWrite = cnt_done; bus.PCwrite = cnt_done; bus.PCSource = PCS_ALURES;
      end
      S_DECODE: begin bus.AluSrcB = SRCB_SEXT_SH; bus.ALUControl = ALU_ADD; end
      S_EXEC_R: begin bus.AluSrcA = 1'b1; bus.AluSrcB = SRCB_B; bus.ALUControl = alu_q; end
      S_WB_R: begin
        bus.RegDest = RDST_RD; bus.MemToReg = M2R_WSRC; bus.WriteSrc = WSRC_ALUOUT;
        bus.RegWrite = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        bus.AluSrcA = 1'b1; bus.AluSrcB = SRCB_SEXT; bus.ALUControl = ALU_ADD;
      end
      S_WB_I:   begin bus.RegDest = RDST_RT; bus.RegWrite = 1'b1; end
      S_SH_LD:  bus.ShiftControl = SH_LOAD;
      S_SH_OP:  bus.ShiftControl = alt_q ? SH_SRL : SH_SLL;
      S_SH_WB:  begin bus.MemToReg = M2R_SHIFT; bus.RegDest = RDST_RD; bus.RegWrite = 1'b1; end
      S_MEM_RD: begin bus.IorD = 1'b1; bus.MemRead = 1'b1; end
      S_WB_MEM: begin bus.MemToReg = M2R_MDR; bus.RegDest = RDST_RT; bus.RegWrite = 1'b1; end
      S_MEM_WR: bus.MemWrite = 1'b1;
      S_BRANCH: begin
        bus.AluSrcA = 1'b1; bus.AluSrcB = SRCB_B; bus.ALUControl = ALU_SUB;
        bus.PCSource = PCS_ALUOUT; bus.PCwrite = alt_q ? ~bus.Zero : bus.Zero;
      end
      S_JUMP:   begin bus.PCSource = PCS_JUMP; bus.PCwrite = 1'b1; end
      S_JR: begin
        bus.AluSrcA = 1'b1; bus.ALUControl = ALU_PASS; bus.PCSource = PCS_ALURES;
        bus.PCwrite = 1'b1;
      end
      S_WB_HL: begin
        bus.WriteSrc = alt_q ? WSRC_LO : WSRC_HI; bus.RegDest = RDST_RD; bus.RegWrite = 1'b1;
      end
      // A divide-by-zero seen on a single-cycle MULDIV must still block HI/LO.
      S_MULDIV: if (cnt_done && !div0) begin
        bus.HIWrite = 1'b1; bus.LOWrite = 1'b1; bus.DivMult = ~alt_q;
      end
      S_EXC1:   begin bus.AluSrcB = SRCB_4; bus.ALUControl = ALU_SUB; end
      S_EXC2: begin
        bus.IorD = 1'b1; bus.MemRead = 1'b1; bus.Exception = exc_q;
        bus.EPCWrite = (cnt == LD_MEM);
      end
      S_EXC3:   begin bus.PCSource = PCS_VECTOR; bus.PCwrite = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output vectors are
// queued by the stimulus and popped/compared by a negedge monitor.
module tb_control_unit;
  localparam int unsigned MW = 2;
  localparam int unsigned MD = 32;

  typedef struct packed {
    logic pcw, memw, memr, irw, regw, epcw, hiw, low, iord, srca;
    logic [3:0] srcb;
    logic [2:0] aluc, shc;
    logic [3:0] pcs, rdst, m2r, wsrc, exc;
    logic dm;
  } ov_t;

  typedef struct {
    string nm;
    ov_t   v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  control_unit_if bus();

  control_unit #(.MEM_WAIT(MW), .MULDIV_CYCLES(MD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ov_t  act;
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  assign act = {bus.PCwrite, bus.MemWrite, bus.MemRead, bus.IRWrite, bus.RegWrite,
                bus.EPCWrite, bus.HIWrite, bus.LOWrite, bus.IorD, bus.AluSrcA,
                bus.AluSrcB, bus.ALUControl, bus.ShiftControl, bus.PCSource,
                bus.RegDest, bus.MemToReg, bus.WriteSrc, bus.Exception, bus.DivMult};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got %h want %h (t=%0t)", e.nm, act, e.v, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.Zero = 1'b0; bus.ALUoverflow = 1'b0; bus.ByZero = 1'b0;
  endtask

  task automatic push(input string nm, input ov_t v);
    exp_t e;
    e.nm = nm; e.v = v;
    sb.push_back(e);
  endtask

  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
    ov_t v;
    for (int i = 0; i <= int'(MW); i++) begin
      tick();
      bus.OPCODE = op; bus.FUNCT = fn;
      v = '0; v.memr = 1'b1; v.srcb = 4'd1; v.aluc = 3'b001;
      if (i == int'(MW)) begin v.irw = 1'b1; v.pcw = 1'b1; end
      push("fetch", v);
    end
    tick();
    v = '0; v.srcb = 4'd3; v.aluc = 3'b001;
    push("decode", v);
  endtask

  task automatic do_exc(input logic [3:0] code);
    ov_t v;
    tick(); v = '0; v.srcb = 4'd1; v.aluc = 3'b010; push("exc1", v);
    for (int i = 0; i < int'(MW); i++) begin
      tick(); v = '0; v.iord = 1'b1; v.memr = 1'b1; v.exc = code; v.epcw = (i == 0);
      push("exc2", v);
    end
    tick(); v = '0; v.pcs = 4'd3; v.pcw = 1'b1; push("exc3", v);
  endtask

  task automatic do_ralu(input logic [5:0] fn, input logic [2:0] aluc, input logic ovf,
                         input logic trap);
    ov_t v;
    do_fetch(6'h00, fn);
    tick(); bus.ALUoverflow = ovf;
    v = '0; v.srca = 1'b1; v.aluc = aluc; push("exec_r", v);
    if (trap) do_exc(4'd1);
    else begin
      tick(); v = '0; v.rdst = 4'd1; v.regw = 1'b1; push("wb_r", v);
    end
  endtask

  task automatic do_addi(input logic ovf);
    ov_t v;
    do_fetch(6'h08, 6'h00);
    tick(); bus.ALUoverflow = ovf;
    v = '0; v.srca = 1'b1; v.srcb = 4'd2; v.aluc = 3'b001; push("exec_i", v);
    if (ovf) do_exc(4'd1);
    else begin
      tick(); v = '0; v.regw = 1'b1; push("wb_i", v);
    end
  endtask

  task automatic do_shift(input logic srl);
    ov_t v;
    do_fetch(6'h00, srl ? 6'h02 : 6'h00);
    tick(); v = '0; v.shc = 3'b001; push("sh_ld", v);
    tick(); v = '0; v.shc = srl ? 3'b011 : 3'b010; push("sh_op", v);
    tick(); v = '0; v.m2r = 4'd2; v.rdst = 4'd1; v.regw = 1'b1; push("sh_wb", v);
  endtask

  task automatic do_mem(input logic store);
    ov_t v;
    do_fetch(store ? 6'h2B : 6'h23, 6'h00);
    tick(); v = '0; v.srca = 1'b1; v.srcb = 4'd2; v.aluc = 3'b001; push("addr", v);
    if (store) begin
      tick(); v = '0; v.memw = 1'b1; push("mem_wr", v);
    end else begin
      for (int i = 0; i < int'(MW); i++) begin
        tick(); v = '0; v.iord = 1'b1; v.memr = 1'b1; push("mem_rd", v);
      end
      tick(); v = '0; v.m2r = 4'd1; v.regw = 1'b1; push("wb_mem", v);
    end
  endtask

  task automatic do_branch(input logic [5:0] op, input logic z, input logic take);
    ov_t v;
    do_fetch(op, 6'h00);
    tick(); bus.Zero = z;
    v = '0; v.srca = 1'b1; v.aluc = 3'b010; v.pcs = 4'd1; v.pcw = take;
    push(op == 6'h04 ? "beq" : "bne", v);
  endtask

  task automatic do_muldiv(input logic div, input logic byz);
    ov_t v;
    do_fetch(6'h00, div ? 6'h1A : 6'h18);
    for (int i = 0; i < int'(MD); i++) begin
      tick();
      if (i == 0) bus.ByZero = byz;
      v = '0;
      if (i == int'(MD) - 1) begin v.hiw = 1'b1; v.low = 1'b1; v.dm = ~div; end
      push("muldiv", v);
      if (div && byz) break;
    end
    if (div && byz) do_exc(4'd2);
  endtask

  initial begin
    ov_t v;
    bus.OPCODE = '0; bus.FUNCT = '0;
    bus.Zero = 1'b0; bus.ALUoverflow = 1'b0; bus.ByZero = 1'b0;

    tick(); push("in_reset", '0);
    tick(); reset = 1'b0; push("rst_release", '0);
    tick(); bus.OPCODE = 6'h00; bus.FUNCT = 6'h20;
    v = '0; v.memr = 1'b1; v.srcb = 4'd1; v.aluc = 3'b001; push("fetch0", v);
    tick(); reset = 1'b1; push("rst_mid_fetch", '0);
    tick(); reset = 1'b0; push("rst_hold", '0);

    do_ralu(6'h20, 3'b001, 1'b0, 1'b0);   // add 1+2
    do_ralu(6'h20, 3'b001, 1'b1, 1'b1);   // add 0x7FFFFFFF+1
    do_ralu(6'h22, 3'b010, 1'b1, 1'b1);   // sub overflow
    do_ralu(6'h22, 3'b010, 1'b0, 1'b0);
    do_ralu(6'h24, 3'b011, 1'b1, 1'b0);   // and ignores overflow
    do_branch(6'h04, 1'b1, 1'b1);
    do_branch(6'h05, 1'b1, 1'b0);
    do_branch(6'h04, 1'b0, 1'b0);
    do_branch(6'h05, 1'b0, 1'b1);
    do_muldiv(1'b1, 1'b1);
    do_muldiv(1'b0, 1'b0);
    do_muldiv(1'b1, 1'b0);
    do_mem(1'b0);
    do_fetch(6'h3F, 6'h00); do_exc(4'd0);
    do_fetch(6'h00, 6'h3F); do_exc(4'd0);
    do_addi(1'b0);
    do_addi(1'b1);
    do_shift(1'b0);
    do_shift(1'b1);
    do_mem(1'b1);

    do_fetch(6'h02, 6'h00);
    tick(); v = '0; v.pcs = 4'd2; v.pcw = 1'b1; push("j", v);
    do_fetch(6'h00, 6'h08);
    tick(); v = '0; v.srca = 1'b1; v.pcw = 1'b1; push("jr", v);
    do_fetch(6'h00, 6'h10);
    tick(); v = '0; v.wsrc = 4'd1; v.rdst = 4'd1; v.regw = 1'b1; push("mfhi", v);
    do_fetch(6'h00, 6'h12);
    tick(); v = '0; v.wsrc = 4'd2; v.rdst = 4'd1; v.regw = 1'b1; push("mflo", v);
    tick(); v = '0; v.memr = 1'b1; v.srcb = 4'd1; v.aluc = 3'b001; push("back_to_fetch", v);

    @(negedge clk); #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
